// File: rtl/pi_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_link_pkg
// Description : Shared definitions for the Raspberry Pi PMOD link (both the
//               Pi-to-FPGA and FPGA-to-Pi directions).
//               - PMOD_W       : width of the PMOD data bus
//               - SYNC_STAGES  : depth of the ack/req pin synchronisers
//               - link_state_t : four-phase handshake state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package pi_link_pkg;

    localparam int PMOD_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ_HI  = 2'd2,
        WAIT_LO = 2'd3
    } link_state_t;

endpackage : pi_link_pkg
`default_nettype wire

// File: rtl/pi_tx_handshake_if.sv
`default_nettype none
// ============================================================================
// Module      : pi_tx_handshake_if
// Description : Fabric byte stream plus PMOD handshake pins of the FPGA-to-Pi
//               transmitter.
//               tx_data/tx_valid/tx_ready : fabric valid/ready byte stream
//               pi_ack_raw                : asynchronous ack pin from the Pi
//               pmod_out/fpga_req         : byte and request strobe to the Pi
//               busy/timeout_err          : status
//               master : fabric + Pi side (drives tx_*, pi_ack_raw)
//               slave  : transmitter side
// Revision    : 1.0 - initial release
// ============================================================================
interface pi_tx_handshake_if;
    import pi_link_pkg::*;

    logic [PMOD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              pi_ack_raw;
    logic [PMOD_W-1:0] pmod_out;
    logic              fpga_req;
    logic              busy;
    logic              timeout_err;

    modport master (
        output tx_data, tx_valid, pi_ack_raw,
        input  tx_ready, pmod_out, fpga_req, busy, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid, pi_ack_raw,
        output tx_ready, pmod_out, fpga_req, busy, timeout_err
    );

endinterface : pi_tx_handshake_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. dout always shows
//               the head entry; rd_en pops it. Writes while full and reads
//               while empty are ignored.
//               clk, reset      : clock, synchronous active-high reset
//               wr_en, din      : push
//               rd_en, dout     : pop / head data
//               full, empty     : status flags
//               count           : number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,   // power of two
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     wr_en,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     rd_en,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int               c_AW      = $clog2(DEPTH);
    localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);
    localparam logic [c_AW:0]    c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW:0]    c_CNT_MAX = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    assign full  = (r_count == c_CNT_MAX);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/pi_tx_handshake.sv
`default_nettype none
// ============================================================================
// Module      : pi_tx_handshake
// Description : FPGA-to-Raspberry-Pi byte transmitter over the 8-bit PMOD
//               bus using a four-phase req/ack handshake. Fabric bytes are
//               buffered in a small FIFO; each byte is presented on pmod_out,
//               held for SETUP_CYCLES, then strobed with fpga_req until the
//               Pi acks. Each ack edge is guarded by an optional timeout.
//               clk, reset : clock, synchronous active-high reset
//               bus        : pi_tx_handshake_if.slave
//                            (tx_data/tx_valid/tx_ready, pi_ack_raw,
//                             pmod_out, fpga_req, busy, timeout_err)
// Revision    : 1.0 - initial release
// ============================================================================
module pi_tx_handshake
    import pi_link_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,        // power of two, 2..16
    parameter int SETUP_CYCLES   = 2,        // 1..15
    parameter int TIMEOUT_CYCLES = 1000000   // 0 disables the timeout
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pi_tx_handshake_if.slave bus
);

    localparam int               c_CW           = $clog2(FIFO_DEPTH) + 1;
    localparam int               c_TW           = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0]       c_SETUP_LAST   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]       c_SETUP_ONE    = 4'd1;
    localparam logic [c_TW-1:0]  c_TIMEOUT_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0]  c_TO_ONE       = c_TW'(1);
    localparam logic             c_TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    logic [SYNC_STAGES-1:0] r_ack_sync;   // [0] = ack_p1, [last] = ack
    logic                   w_ack;
    link_state_t            r_state;
    logic [PMOD_W-1:0]      r_pmod;
    logic                   r_req;
    logic                   r_err;
    logic                   r_avail;
    logic [3:0]             r_setup_cnt;
    logic [c_TW-1:0]        r_to_cnt;
    logic                   w_timeout;
    logic                   w_pop;
    logic [PMOD_W-1:0]      w_fifo_dout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_CW-1:0]        w_fifo_count;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PMOD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (bus.tx_valid),
        .din   (bus.tx_data),
        .rd_en (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Ack pin synchroniser; the FSM only ever looks at the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.pi_ack_raw};
        end
    end

    assign w_ack     = r_ack_sync[SYNC_STAGES-1];
    assign w_timeout = c_TIMEOUT_EN && (r_to_cnt == c_TIMEOUT_LAST);

    // r_avail is the FIFO non-empty flag one cycle late, which keeps the
    // fabric write off the pop/load path. Its lag after a pop is harmless:
    // the FSM spends at least three cycles away from IDLE per byte.
    assign w_pop = (r_state == IDLE) && r_avail && !w_ack && !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pmod      <= '0;
            r_req       <= 1'b0;
            r_err       <= 1'b0;
            r_avail     <= 1'b0;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_avail <= !w_fifo_empty;
            case (r_state)
                IDLE: begin
                    // A Pi still holding ack high blocks the next byte.
                    if (w_pop) begin
                        r_pmod      <= w_fifo_dout;
                        r_setup_cnt <= '0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_setup_cnt == c_SETUP_LAST) begin
                        r_req    <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= REQ_HI;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + c_SETUP_ONE;
                    end
                end
                REQ_HI: begin
                    if (w_ack) begin
                        r_req    <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= WAIT_LO;
                    end else if (w_timeout) begin
                        // Abandon the byte; no retry.
                        r_err    <= 1'b1;
                        r_req    <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= WAIT_LO;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end
                end
                WAIT_LO: begin
                    if (!w_ack) begin
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = !w_fifo_full;
    assign bus.pmod_out    = r_pmod;
    assign bus.fpga_req    = r_req;
    assign bus.timeout_err = r_err;
    assign bus.busy        = (w_fifo_count != '0) || (r_state != IDLE);

endmodule : pi_tx_handshake
`default_nettype wire
